// File: rtl/high_bit_decode.sv
// Rebuilds a word from the index of its highest set bit, as a one-hot or a
// thermometer mask, through a two-stage valid/ready pipeline.
module high_bit_decode #(
  parameter  int OUTPUT_WIDTH = 8,
  localparam int INDEX_WIDTH  = $clog2(OUTPUT_WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INDEX_WIDTH-1:0]  in_index,
  input  logic                    in_zero,
  input  logic                    in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_data,
  output logic                    out_error,
  output logic [15:0]             err_count
);

  logic                   s1_valid;
  logic [INDEX_WIDTH-1:0] s1_index;
  logic                   s1_zero;
  logic                   s1_mode;
  logic                   s1_load;
  logic                   s2_load;
  logic [OUTPUT_WIDTH:0]  one_wide;
  logic [OUTPUT_WIDTH:0]  therm_wide;
  logic                   idx_oor;
  logic [OUTPUT_WIDTH-1:0] dec_data;
  logic                   dec_error;

  // out_ready feeds in_ready combinationally so a draining sink frees S1 at once
  assign in_ready = rst_n && (!s1_valid || !out_valid || out_ready);
  assign s1_load  = in_valid && in_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  always_comb begin
    one_wide   = (OUTPUT_WIDTH+1)'(1) << s1_index;
    // one extra bit so index OUTPUT_WIDTH-1 wraps to all ones after truncation
    therm_wide = (one_wide << 1) - (OUTPUT_WIDTH+1)'(1);
    idx_oor    = 32'(s1_index) >= 32'(OUTPUT_WIDTH);
    dec_data   = '0;
    dec_error  = 1'b0;
    if (s1_zero) begin
      dec_data = '0;
    end else if (idx_oor) begin
      dec_error = 1'b1;
    end else if (s1_mode) begin
      dec_data = therm_wide[OUTPUT_WIDTH-1:0];
    end else begin
      dec_data = one_wide[OUTPUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_index <= '0;
      s1_zero  <= 1'b0;
      s1_mode  <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= 1'b1;
      s1_index <= in_index;
      s1_zero  <= in_zero;
      s1_mode  <= in_mode;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_error <= 1'b0;
    end else if (s2_load) begin
      out_valid <= 1'b1;
      out_data  <= dec_data;
      out_error <= dec_error;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (out_valid && out_ready && out_error && (err_count != 16'hFFFF)) begin
      err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_high_bit_decode.sv
// Directed bench for high_bit_decode: an 8-bit instance for decode, throughput
// and backpressure, a 6-bit instance for range errors and reset.
module tb_high_bit_decode;

  logic clk;
  logic rst_n;

  logic       a_in_valid, a_in_ready, a_in_zero, a_in_mode;
  logic [2:0] a_in_index;
  logic       a_out_valid, a_out_ready, a_out_error;
  logic [7:0] a_out_data;
  logic [15:0] a_err_count;

  logic       b_in_valid, b_in_ready, b_in_zero, b_in_mode;
  logic [2:0] b_in_index;
  logic       b_out_valid, b_out_ready, b_out_error;
  logic [5:0] b_out_data;
  logic [15:0] b_err_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] a_q_data[$];
  logic       a_q_err[$];
  int         a_q_lat[$];
  int         a_q_cyc[$];
  int         a_acc[$];
  logic [5:0] b_q_data[$];
  logic       b_q_err[$];

  high_bit_decode #(.OUTPUT_WIDTH(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_index(a_in_index),
    .in_zero(a_in_zero), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_error(a_out_error), .err_count(a_err_count)
  );

  high_bit_decode #(.OUTPUT_WIDTH(6)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_index(b_in_index),
    .in_zero(b_in_zero), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_error(b_out_error), .err_count(b_err_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // handshakes are stable mid-cycle; a sample at negedge k is the transfer at the next posedge
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (a_out_valid && a_out_ready) begin
          a_q_data.push_back(a_out_data);
          a_q_err.push_back(a_out_error);
          a_q_cyc.push_back(cyc);
          if (a_acc.size() > 0) a_q_lat.push_back(cyc - a_acc.pop_front());
          else a_q_lat.push_back(-1);
        end
        if (a_in_valid && a_in_ready) a_acc.push_back(cyc);
        if (b_out_valid && b_out_ready) begin
          b_q_data.push_back(b_out_data);
          b_q_err.push_back(b_out_error);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_queues();
    a_q_data.delete(); a_q_err.delete(); a_q_lat.delete(); a_q_cyc.delete(); a_acc.delete();
    b_q_data.delete(); b_q_err.delete();
  endtask

  task automatic send(input bit sel, input logic [2:0] idx, input logic z, input logic m);
    int guard;
    guard = 0;
    if (!sel) begin
      a_in_valid = 1'b1; a_in_index = idx; a_in_zero = z; a_in_mode = m;
    end else begin
      b_in_valid = 1'b1; b_in_index = idx; b_in_zero = z; b_in_mode = m;
    end
    @(negedge clk);
    while (!(sel ? b_in_ready : a_in_ready) && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      total++; bad++;
      $display("FAIL send_timeout sel=%0d got in_ready=0 want 1", sel);
    end
    @(posedge clk); #1;
    if (!sel) a_in_valid = 1'b0;
    else b_in_valid = 1'b0;
  endtask

  task automatic wait_out(input bit sel, input int n);
    int guard;
    guard = 0;
    while (((sel ? b_q_data.size() : a_q_data.size()) < n) && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    total++;
    if ((sel ? b_q_data.size() : a_q_data.size()) < n) begin
      bad++;
      $display("FAIL wait_out sel=%0d got %0d beats want %0d", sel,
               sel ? b_q_data.size() : a_q_data.size(), n);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    a_in_valid = 0; a_in_index = 0; a_in_zero = 0; a_in_mode = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_index = 0; b_in_zero = 0; b_in_mode = 0; b_out_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    total += 7;
    if (a_in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got %b want 0", a_in_ready); end
    if (a_out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got %b want 0", a_out_valid); end
    if (a_out_data !== 8'h00) begin bad++; $display("FAIL rst_out_data got %h want 00", a_out_data); end
    if (a_out_error !== 1'b0) begin bad++; $display("FAIL rst_out_error got %b want 0", a_out_error); end
    if (a_err_count !== 16'h0) begin bad++; $display("FAIL rst_err_count got %h want 0", a_err_count); end
    if (b_in_ready !== 1'b0) begin bad++; $display("FAIL rst_b_in_ready got %b want 0", b_in_ready); end
    if (b_err_count !== 16'h0) begin bad++; $display("FAIL rst_b_err_count got %h want 0", b_err_count); end
    rst_n = 1'b1;
    @(posedge clk); #1;
    total += 2;
    if (a_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_in_ready got %b want 1", a_in_ready); end
    if (b_in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_b_in_ready got %b want 1", b_in_ready); end
  endtask

  task automatic test_sweep(input logic mode, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3);
    logic [2:0] idx [4];
    logic [7:0] exp_d [4];
    idx = '{3'd7, 3'd1, 3'd4, 3'd0};
    exp_d = '{e0, e1, e2, e3};
    clear_queues();
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, idx[i], 1'b0, mode);
    wait_out(1'b0, 4);
    for (int i = 0; i < 4 && i < a_q_data.size(); i++) begin
      total += 3;
      if (a_q_data[i] !== exp_d[i]) begin bad++; $display("FAIL sweep_m%0d_data[%0d] got %h want %h", mode, i, a_q_data[i], exp_d[i]); end
      if (a_q_err[i] !== 1'b0) begin bad++; $display("FAIL sweep_m%0d_err[%0d] got %b want 0", mode, i, a_q_err[i]); end
      if (a_q_lat[i] != 2) begin bad++; $display("FAIL sweep_m%0d_latency[%0d] got %0d want 2", mode, i, a_q_lat[i]); end
      if (i > 0) begin
        total++;
        if (a_q_cyc[i] != a_q_cyc[i-1] + 1) begin bad++; $display("FAIL sweep_m%0d_gap[%0d] got %0d want 1", mode, i, a_q_cyc[i] - a_q_cyc[i-1]); end
      end
    end
  endtask

  task automatic test_zero();
    clear_queues();
    send(1'b0, 3'd5, 1'b1, 1'b0);
    wait_out(1'b0, 1);
    if (a_q_data.size() > 0) begin
      total += 2;
      if (a_q_data[0] !== 8'h00) begin bad++; $display("FAIL zero_data got %h want 00", a_q_data[0]); end
      if (a_q_err[0] !== 1'b0) begin bad++; $display("FAIL zero_err got %b want 0", a_q_err[0]); end
    end
    total++;
    if (a_err_count !== 16'h0) begin bad++; $display("FAIL zero_err_count got %h want 0", a_err_count); end
  endtask

  task automatic test_range();
    logic [2:0] idx [4];
    logic       md  [4];
    logic [5:0] exp_d [4];
    logic       exp_e [4];
    logic [15:0] exp_c [4];
    idx   = '{3'd6, 3'd7, 3'd5, 3'd5};
    md    = '{1'b0, 1'b1, 1'b1, 1'b0};
    exp_d = '{6'h00, 6'h00, 6'h3F, 6'h20};
    exp_e = '{1'b1, 1'b1, 1'b0, 1'b0};
    exp_c = '{16'd1, 16'd2, 16'd2, 16'd2};
    clear_queues();
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, idx[i], 1'b0, md[i]);
      wait_out(1'b1, i + 1);
      if (b_q_data.size() > i) begin
        total += 3;
        if (b_q_data[i] !== exp_d[i]) begin bad++; $display("FAIL range_data[%0d] got %h want %h", i, b_q_data[i], exp_d[i]); end
        if (b_q_err[i] !== exp_e[i]) begin bad++; $display("FAIL range_err[%0d] got %b want %b", i, b_q_err[i], exp_e[i]); end
        if (b_err_count !== exp_c[i]) begin bad++; $display("FAIL range_err_count[%0d] got %0d want %0d", i, b_err_count, exp_c[i]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [2:0] bp_idx  [10];
    logic       bp_mode [10];
    logic [7:0] bp_exp  [10];
    logic [7:0] held;
    logic       accepted;
    int nb, c;
    bp_idx  = '{3'd3, 3'd6, 3'd0, 3'd7, 3'd2, 3'd5, 3'd1, 3'd4, 3'd7, 3'd0};
    bp_mode = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bp_exp  = '{8'h08, 8'h7F, 8'h01, 8'h80, 8'h07, 8'h20, 8'h03, 8'h1F, 8'hFF, 8'h01};
    held = 8'h00;
    nb = 0;
    c = 0;
    clear_queues();
    while (nb < 10 && c < 100) begin
      a_out_ready = !(c >= 4 && c < 9);
      a_in_valid = 1'b1; a_in_index = bp_idx[nb]; a_in_mode = bp_mode[nb]; a_in_zero = 1'b0;
      @(negedge clk);
      if (c == 4) held = a_out_data;
      if (c >= 4 && c < 9) begin
        total += 2;
        if (a_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got %b want 0", c, a_in_ready); end
        if (a_out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d got %b want 1", c, a_out_valid); end
      end
      if (c >= 5 && c < 9) begin
        total++;
        if (a_out_data !== held) begin bad++; $display("FAIL bp_stable c=%0d got %h want %h", c, a_out_data, held); end
      end
      if (c == 8) begin
        total++;
        if (nb - a_q_data.size() != 2) begin bad++; $display("FAIL bp_buffered got %0d want 2", nb - a_q_data.size()); end
      end
      accepted = a_in_valid && a_in_ready;
      @(posedge clk); #1;
      if (accepted) nb++;
      c++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    wait_out(1'b0, 10);
    total++;
    if (a_q_data.size() != 10) begin bad++; $display("FAIL bp_count got %0d want 10", a_q_data.size()); end
    for (int i = 0; i < 10 && i < a_q_data.size(); i++) begin
      total++;
      if (a_q_data[i] !== bp_exp[i]) begin bad++; $display("FAIL bp_order[%0d] got %h want %h", i, a_q_data[i], bp_exp[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    clear_queues();
    b_out_ready = 1'b1;
    send(1'b1, 3'd7, 1'b0, 1'b0);
    wait_out(1'b1, 1);
    total++;
    if (b_err_count !== 16'd3) begin bad++; $display("FAIL mid_pre_err_count got %0d want 3", b_err_count); end
    b_out_ready = 1'b0;
    send(1'b1, 3'd1, 1'b0, 1'b0);
    send(1'b1, 3'd2, 1'b0, 1'b0);
    total += 2;
    if (b_out_valid !== 1'b1) begin bad++; $display("FAIL mid_full_valid got %b want 1", b_out_valid); end
    if (b_in_ready !== 1'b0) begin bad++; $display("FAIL mid_full_in_ready got %b want 0", b_in_ready); end
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (b_out_valid !== 1'b0) begin bad++; $display("FAIL mid_rst_valid got %b want 0", b_out_valid); end
    if (b_err_count !== 16'd0) begin bad++; $display("FAIL mid_rst_err_count got %0d want 0", b_err_count); end
    if (b_in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got %b want 0", b_in_ready); end
    if (a_in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_a_in_ready got %b want 0", a_in_ready); end
    @(posedge clk); #1;
    rst_n = 1'b1;
    clear_queues();
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    @(posedge clk); #1;
    send(1'b0, 3'd3, 1'b0, 1'b1);
    wait_out(1'b0, 1);
    if (a_q_data.size() > 0) begin
      total += 2;
      if (a_q_data[0] !== 8'h0F) begin bad++; $display("FAIL post_mid_data got %h want 0F", a_q_data[0]); end
      if (a_q_lat[0] != 2) begin bad++; $display("FAIL post_mid_latency got %0d want 2", a_q_lat[0]); end
    end
    total += 2;
    if (b_q_data.size() != 0) begin bad++; $display("FAIL post_mid_discard got %0d beats want 0", b_q_data.size()); end
    if (b_out_valid !== 1'b0) begin bad++; $display("FAIL post_mid_b_valid got %b want 0", b_out_valid); end
  endtask

  initial begin
    test_reset();
    test_sweep(1'b0, 8'h80, 8'h02, 8'h10, 8'h01);
    test_sweep(1'b1, 8'hFF, 8'h03, 8'h1F, 8'h01);
    test_zero();
    test_range();
    test_backpressure();
    test_reset_midstream();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
